// File: rtl/config_pkg.sv
// config_pkg: shared opcodes, error byte and FSM state encoding for packet_engine
package config_pkg;
    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD   = 8'hAD;
    localparam logic [7:0] OP_MUL   = 8'h88;
    localparam logic [7:0] ERR_BYTE = 8'hEE;
    typedef enum logic [3:0] {
        S_OPCODE   = 4'd0,
        S_RESERVED = 4'd1,
        S_LEN_LO   = 4'd2,
        S_LEN_HI   = 4'd3,
        S_ECHO     = 4'd4,
        S_OPERAND  = 4'd5,
        S_MUL_WAIT = 4'd6,
        S_SEND     = 4'd7,
        S_DRAIN    = 4'd8
    } state_t;
endpackage

// File: rtl/iter_mul.sv
// iter_mul: shift-add multiplier, one multiplier bit per cycle, product modulo 2^AW
// Ports: clk, rst (sync, active-high); start loads a/b; done pulses in the last
// of BW busy cycles, with p valid in that same cycle.
module iter_mul #(
    parameter int AW = 64,
    parameter int BW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic          done,
    output logic [AW-1:0] p
);
    localparam int CW = $clog2(BW + 1);
    logic [AW-1:0] r_a, r_p;
    logic [BW-1:0] r_b;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_next;
    always_comb begin
        w_next = r_p + (r_b[0] ? r_a : '0);
        done   = r_cnt == CW'(1);
        p      = w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_p   <= '0;
            r_cnt <= CW'(BW);
        end else if (r_cnt != '0) begin
            r_p   <= w_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/packet_engine.sv
// packet_engine: byte-stream packet processor (ECHO / ADD / MUL) with drain of bad packets
// Ports: clk, rst (sync, active-high); data_i/valid_i/ready_o upstream byte handshake;
// data_o/valid_o/ready_i downstream byte handshake; state_o debug state; busy_o.
// Compile option: PACKET_ENGINE_ERR_RESP_EN adds a 0xEE response after DRAIN.
module packet_engine
    import config_pkg::*;
#(
    parameter int OPERAND_BYTES = 4,
    parameter int RESULT_BYTES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [3:0] state_o,
    output logic       busy_o
);
    localparam int OW = 8 * OPERAND_BYTES;
    localparam int RW = 8 * RESULT_BYTES;
    state_t        r_state;
    logic [7:0]    r_opcode, r_len_lo;
    logic [15:0]   r_cnt;
    logic [2:0]    r_bcnt;
    logic [3:0]    r_scnt;
    logic [OW-1:0] r_shift, r_operand;
    logic [RW-1:0] r_acc;
    logic          r_fold;
    logic          w_in, w_out, w_send, w_last_byte, w_last_pay, w_op_ok;
    logic          w_mul_start, w_mul_done;
    logic [15:0]   w_len, w_pay;
    logic [OW+7:0] w_cat;
    logic [OW-1:0] w_full;
    logic [RW-1:0] w_prod;
    // SEND holds off valid_o while an ADD operand is still being folded in
    always_comb begin
        w_send      = r_state == S_SEND && !r_fold;
        ready_o     = (r_state == S_ECHO) ? ready_i :
                      (r_state == S_MUL_WAIT || r_state == S_SEND) ? 1'b0 : 1'b1;
        valid_o     = (r_state == S_ECHO) ? valid_i : w_send;
        data_o      = (r_state == S_ECHO) ? data_i : w_send ? r_acc[RW-1 -: 8] : 8'd0;
        state_o     = r_state;
        busy_o      = r_state != S_OPCODE;
        w_in        = valid_i && ready_o;
        w_out       = valid_o && ready_i;
        w_len       = {data_i, r_len_lo};
        w_pay       = w_len - 16'd4;
        w_cat       = {r_shift, data_i};
        w_full      = w_cat[OW-1:0];
        w_last_byte = r_bcnt == 3'(OPERAND_BYTES - 1);
        w_last_pay  = r_cnt == 16'd1;
        w_op_ok     = (r_opcode == OP_ADD || r_opcode == OP_MUL) &&
                      (w_pay % 16'(OPERAND_BYTES)) == 16'd0;
        w_mul_start = r_state == S_OPERAND && w_in && w_last_byte && r_opcode == OP_MUL;
    end
    iter_mul #(.AW(RW), .BW(OW)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_mul_start),
        .a     (r_acc),
        .b     (w_full),
        .done  (w_mul_done),
        .p     (w_prod)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_OPCODE;
            r_opcode  <= '0;
            r_len_lo  <= '0;
            r_cnt     <= '0;
            r_bcnt    <= '0;
            r_scnt    <= '0;
            r_shift   <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_fold    <= 1'b0;
        end else begin
            r_fold <= 1'b0;
            if (r_fold) r_acc <= r_acc + RW'(r_operand);
            case (r_state)
                S_OPCODE: if (w_in) begin
                    r_opcode <= data_i;
                    r_state  <= S_RESERVED;
                end
                S_RESERVED: if (w_in) r_state <= S_LEN_LO;
                S_LEN_LO: if (w_in) begin
                    r_len_lo <= data_i;
                    r_state  <= S_LEN_HI;
                end
                S_LEN_HI: if (w_in) begin
                    r_cnt   <= w_pay;
                    r_bcnt  <= '0;
                    r_acc   <= (r_opcode == OP_MUL) ? RW'(1) : '0;
                    r_state <= (w_len <= 16'd4) ? S_OPCODE :
                               (r_opcode == OP_ECHO) ? S_ECHO :
                               w_op_ok ? S_OPERAND : S_DRAIN;
                end
                S_ECHO: if (w_in) begin
                    r_cnt <= r_cnt - 16'd1;
                    if (w_last_pay) r_state <= S_OPCODE;
                end
                S_OPERAND: if (w_in) begin
                    r_cnt   <= r_cnt - 16'd1;
                    r_shift <= w_full;
                    r_bcnt  <= w_last_byte ? 3'd0 : r_bcnt + 3'd1;
                    if (w_last_byte && r_opcode == OP_MUL) r_state <= S_MUL_WAIT;
                    else if (w_last_byte) begin
                        r_operand <= w_full;
                        r_fold    <= 1'b1;
                        if (w_last_pay) begin
                            r_state <= S_SEND;
                            r_scnt  <= 4'(RESULT_BYTES);
                        end
                    end
                end
                S_MUL_WAIT: if (w_mul_done) begin
                    r_acc   <= w_prod;
                    r_scnt  <= 4'(RESULT_BYTES);
                    r_state <= (r_cnt == 16'd0) ? S_SEND : S_OPERAND;
                end
                S_SEND: if (w_out) begin
                    r_acc  <= r_acc << 8;
                    r_scnt <= r_scnt - 4'd1;
                    if (r_scnt == 4'd1) r_state <= S_OPCODE;
                end
                S_DRAIN: if (w_in) begin
                    r_cnt <= r_cnt - 16'd1;
                    if (w_last_pay) begin
`ifdef PACKET_ENGINE_ERR_RESP_EN
                        // reuse SEND as a one-byte response with the error code on top
                        r_acc   <= RW'(ERR_BYTE) << (RW - 8);
                        r_scnt  <= 4'd1;
                        r_state <= S_SEND;
`else
                        r_state <= S_OPCODE;
`endif
                    end
                end
                default: r_state <= S_OPCODE;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_engine.sv
// tb_packet_engine: directed self-checking bench for packet_engine (default and 2/4-byte builds)
module tb_packet_engine;
    logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
    logic [7:0] din = 8'd0;
    logic vin = 1'b0, rin = 1'b0;
    logic [7:0] d1, d2;
    logic v1, v2, r1, r2, b1, b2;
    logic [3:0] s1, s2;
    wire [7:0] dout = sel ? d2 : d1;
    wire vout = sel ? v2 : v1;
    wire rdy  = sel ? r2 : r1;
    wire busy = sel ? b2 : b1;
    wire [3:0] st = sel ? s2 : s1;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    packet_engine u_dut (
        .clk(clk), .rst(rst), .data_i(din), .valid_i(vin && !sel), .ready_o(r1),
        .data_o(d1), .valid_o(v1), .ready_i(rin && !sel), .state_o(s1), .busy_o(b1)
    );
    packet_engine #(.OPERAND_BYTES(2), .RESULT_BYTES(4)) u_dut2 (
        .clk(clk), .rst(rst), .data_i(din), .valid_i(vin && sel), .ready_o(r2),
        .data_o(d2), .valid_o(v2), .ready_i(rin && sel), .state_o(s2), .busy_o(b2)
    );

    task automatic put(input logic [7:0] b);
        int n = 0;
        din = b;
        vin = 1'b1;
        @(negedge clk);
        while (!rdy && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        vin = 1'b0;
        if (n >= 200) begin errors++; $display("FAIL put_timeout byte=%h", b); end
    endtask

    task automatic put_word(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) put(v[i*8 +: 8]);
    endtask

    task automatic get(input int n, output logic [63:0] v);
        int m;
        v = '0;
        rin = 1'b1;
        for (int i = 0; i < n; i++) begin
            m = 0;
            @(negedge clk);
            while (!vout && m < 200) begin @(negedge clk); m++; end
            v = {v[55:0], (m >= 200) ? 8'hxx : dout};
            @(posedge clk); #1;
        end
        rin = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (st !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", st); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (vout !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", vout); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", dout); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", rdy); end
    endtask

    task automatic test_add();
        logic [63:0] v;
        put_word(32'hAD000C00, 4);
        checks++; if (busy !== 1'b1 || st !== 4'd5) begin errors++; $display("FAIL add_operand_state got=%0d/%b exp=5/1", st, busy); end
        put_word(64'h00000001_00000002, 8);
        get(8, v);
        checks++; if (v !== 64'h3) begin errors++; $display("FAIL add_result got=%h exp=%h", v, 64'h3); end
        checks++; if (st !== 4'd0) begin errors++; $display("FAIL add_end_state got=%0d exp=0", st); end
    endtask

    task automatic test_mul();
        logic [63:0] v;
        logic [31:0] ops [3];
        int n;
        logic low;
        ops = '{32'hFFFFFFFF, 32'h2, 32'h3};
        put_word(32'h88001000, 4);
        for (int k = 0; k < 3; k++) begin
            put_word({32'h0, ops[k]}, 4);
            n = 0;
            low = 1'b1;
            @(negedge clk);
            while (st == 4'd6 && n < 100) begin
                n++;
                if (rdy) low = 1'b0;
                @(negedge clk);
            end
            @(posedge clk); #1;
            checks++; if (n != 32) begin errors++; $display("FAIL mul_wait_cycles op=%0d got=%0d exp=32", k, n); end
            checks++; if (low !== 1'b1) begin errors++; $display("FAIL mul_ready_low op=%0d got=%b exp=1", k, low); end
        end
        get(8, v);
        checks++; if (v !== 64'h00000005_FFFFFFFA) begin errors++; $display("FAIL mul_result got=%h exp=00000005fffffffa", v); end
    endtask

    task automatic test_echo();
        logic [7:0] got [$];
        logic [7:0] exp [3];
        logic [7:0] g;
        exp = '{8'h11, 8'h22, 8'h33};
        put_word(32'hEC000700, 4);
        checks++; if (st !== 4'd4) begin errors++; $display("FAIL echo_state got=%0d exp=4", st); end
        fork
            put_word(64'h112233, 3);
            for (int i = 0; i < 16; i++) begin @(posedge clk); #1; rin = !rin; end
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                if (vout && rin) got.push_back(dout);
            end
        join
        rin = 1'b0;
        checks++; if (got.size() != 3) begin errors++; $display("FAIL echo_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            checks++; if (g !== exp[i]) begin errors++; $display("FAIL echo_byte%0d got=%h exp=%h", i, g, exp[i]); end
        end
        checks++; if (st !== 4'd0) begin errors++; $display("FAIL echo_end_state got=%0d exp=0", st); end
    endtask

    task automatic test_drain();
        logic [63:0] v;
        logic seen;
        put_word(32'hAD000400, 4);
        checks++; if (st !== 4'd0 || vout !== 1'b0) begin errors++; $display("FAIL len4_idle got=%0d/%b exp=0/0", st, vout); end
        put_word(32'hAD000A00, 4);
        checks++; if (st !== 4'd8) begin errors++; $display("FAIL drain_state got=%0d exp=8", st); end
        put_word(64'h010203040506, 6);
`ifdef PACKET_ENGINE_ERR_RESP_EN
        get(1, v);
        checks++; if (v[7:0] !== 8'hEE) begin errors++; $display("FAIL drain_err_byte got=%h exp=ee", v[7:0]); end
`else
        rin = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (vout) seen = 1'b1; end
        @(posedge clk); #1;
        rin = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL drain_silent got=%b exp=0", seen); end
`endif
        checks++; if (st !== 4'd0) begin errors++; $display("FAIL drain_end_state got=%0d exp=0", st); end
        put_word(32'h55000500, 4);
        checks++; if (st !== 4'd8) begin errors++; $display("FAIL unknown_drain got=%0d exp=8", st); end
        put(8'h99);
`ifdef PACKET_ENGINE_ERR_RESP_EN
        get(1, v);
        checks++; if (v[7:0] !== 8'hEE) begin errors++; $display("FAIL unknown_err_byte got=%h exp=ee", v[7:0]); end
`endif
        checks++; if (st !== 4'd0) begin errors++; $display("FAIL unknown_end_state got=%0d exp=0", st); end
        put_word(32'hAD000800, 4);
        put_word(64'h01020304, 4);
        get(8, v);
        checks++; if (v !== 64'h01020304) begin errors++; $display("FAIL after_drain_add got=%h exp=%h", v, 64'h01020304); end
    endtask

    task automatic test_rst_send();
        logic [63:0] v;
        logic seen;
        put_word(32'hAD000C00, 4);
        put_word(64'h11223344_01010101, 8);
        get(3, v);
        checks++; if (v[23:0] !== 24'h0) begin errors++; $display("FAIL rst_send_first3 got=%h exp=000000", v[23:0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rin = 1'b1;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (vout) seen = 1'b1; end
        @(posedge clk); #1;
        rin = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_send_quiet got=%b exp=0", seen); end
        checks++; if (st !== 4'd0) begin errors++; $display("FAIL rst_send_state got=%0d exp=0", st); end
        put_word(32'hAD000C00, 4);
        put_word(64'h00000005_00000006, 8);
        get(8, v);
        checks++; if (v !== 64'hB) begin errors++; $display("FAIL rst_send_next_add got=%h exp=%h", v, 64'hB); end
    endtask

    task automatic test_small_params();
        logic [63:0] v;
        sel = 1'b1;
        put_word(32'hAD000800, 4);
        put_word(32'hFFFFFFFF, 4);
        get(4, v);
        checks++; if (v[31:0] !== 32'h0001FFFE) begin errors++; $display("FAIL small_add got=%h exp=0001fffe", v[31:0]); end
        checks++; if (st !== 4'd0) begin errors++; $display("FAIL small_end_state got=%0d exp=0", st); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_echo();
        test_drain();
        test_rst_send();
        test_small_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
